// File: rtl/fetch_pkg.sv
// Shared types and opcode-length decode for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    OPC   = 3'd1,
    OP_LO = 3'd2,
    OP_HI = 3'd3,
    HOLD  = 3'd4
  } fetch_state_e;

  localparam int OPLEN_MSB = 7;
  localparam int OPLEN_LSB = 6;

  localparam logic [1:0] LEN_NONE    = 2'b00;
  localparam logic [1:0] LEN_ONE     = 2'b01;
  localparam logic [1:0] LEN_TWO     = 2'b10;
  localparam logic [1:0] LEN_ONE_ALT = 2'b11;

  function automatic logic [1:0] operand_len(input logic [7:0] opcode);
    logic unused_bits;
    unused_bits = ^opcode[OPLEN_LSB-1:0];
    case (opcode[OPLEN_MSB:OPLEN_LSB])
      LEN_NONE:    operand_len = 2'd0;
      LEN_ONE:     operand_len = 2'd1;
      LEN_TWO:     operand_len = 2'd2;
      LEN_ONE_ALT: operand_len = 2'd1;
      default:     operand_len = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Memory read bus and decoded-instruction handshake of the fetch stage.
interface instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] opcode;
  logic [15:0]       operand;
  logic [ADDR_W-1:0] instr_pc;

  modport master (
    output mem_read, mem_addr, instr_valid, opcode, operand, instr_pc,
    input  mem_data, instr_ready
  );

  modport slave (
    input  mem_read, mem_addr, instr_valid, opcode, operand, instr_pc,
    output mem_data, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, reads opcode plus 0-2 operand bytes from
// byte-wide memory and presents the assembled instruction via valid/ready.
//
//   state | meaning
//   IDLE  | no read, waiting for fetch_req
//   OPC   | reading opcode byte at PC
//   OP_LO | reading operand low byte
//   OP_HI | reading operand high byte
//   HOLD  | instruction presented, waiting for instr_ready
import fetch_pkg::*;

module instr_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  instr_fetch_if.master     bus
);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_OPC   = OPC;
  localparam logic [2:0] ST_OP_LO = OP_LO;
  localparam logic [2:0] ST_OP_HI = OP_HI;
  localparam logic [2:0] ST_HOLD  = HOLD;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [DATA_W-1:0] opcode_q;
  logic [15:0]       operand_q;
  logic [ADDR_W-1:0] instr_pc_q;
  logic              mem_read_q;
  logic              instr_valid_q;
  logic [1:0]        len_new;
  logic [1:0]        len_cur;

  assign len_new = operand_len(bus.mem_data);
  assign len_cur = operand_len(opcode_q);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_IDLE: begin
        if (fetch_req) state_nxt = ST_OPC;
      end
      ST_OPC: begin
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = (len_new == 2'd0) ? ST_HOLD : ST_OP_LO;
      end
      ST_OP_LO: begin
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = (len_cur == 2'd1) ? ST_HOLD : ST_OP_HI;
      end
      ST_OP_HI: begin
        pc_nxt    = pc + ADDR_W'(1);
        state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.instr_ready) state_nxt = fetch_req ? ST_OPC : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A jump overrides everything; a same-cycle handshake has already completed.
    if (jump) begin
      pc_nxt    = jump_addr;
      state_nxt = fetch_req ? ST_OPC : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      pc            <= RESET_PC;
      opcode_q      <= '0;
      operand_q     <= '0;
      instr_pc_q    <= RESET_PC;
      mem_read_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      // Strobes are flopped from the next state so they never glitch.
      mem_read_q    <= (state_nxt == ST_OPC) || (state_nxt == ST_OP_LO) ||
                       (state_nxt == ST_OP_HI);
      instr_valid_q <= (state_nxt == ST_HOLD);
      if (!jump) begin
        case (state)
          ST_OPC: begin
            opcode_q   <= bus.mem_data;
            operand_q  <= '0;
            instr_pc_q <= pc;
          end
          ST_OP_LO: operand_q <= {8'h00, bus.mem_data};
          ST_OP_HI: operand_q[15:8] <= bus.mem_data;
          default: ;
        endcase
      end
    end
  end

  assign bus.mem_read    = mem_read_q;
  assign bus.mem_addr    = pc;
  assign bus.instr_valid = instr_valid_q;
  assign bus.opcode      = opcode_q;
  assign bus.operand     = operand_q;
  assign bus.instr_pc    = instr_pc_q;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the simple CPU, sitting directly upstream of the byte-wide `memory` block. It owns the program counter, drives the memory read strobe and address, assembles a variable-length instruction (1-byte opcode plus 0, 1 or 2 operand bytes) and presents it to the decode/control stage through a valid/ready handshake. It also accepts a jump request from the control unit that redirects the PC and aborts any fetch in progress.

## Interface
- `ADDR_W`, 16, address and PC width; matches the memory address input.
- `DATA_W`, 8, memory data width; opcode width.
- `RESET_PC`, 16'h0000, PC value after reset.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `fetch_req`  in  1  level; control unit wants the next instruction.
- `jump`  in  1  one-cycle pulse; load PC from `jump_addr`.
- `jump_addr`  in  ADDR_W  jump target.
- `mem_read`  out  1  read strobe to memory.
- `mem_addr`  out  ADDR_W  memory address; always equals the current PC.
- `mem_data`  in  DATA_W  memory read data; valid combinationally in the same cycle as `mem_read`.
- `instr_valid`  out  1  instruction outputs are valid.
- `instr_ready`  in  1  consumer accepts the instruction.
- `opcode`  out  DATA_W  fetched opcode.
- `operand`  out  16  operand: zero-extended for 1 byte, little-endian for 2 bytes, 0 for none.
- `instr_pc`  out  ADDR_W  address of the opcode byte of the presented instruction.

## Operation
- Operand length comes from `opcode[7:6]`: 00 means 0 bytes, 01 means 1 byte, 10 means 2 bytes, 11 means 1 byte.
- States:
  - IDLE: no read. Go to OPC when `fetch_req` is 1.
  - OPC: `mem_read`=1. Capture `mem_data` into `opcode`, record `instr_pc`=PC, then PC+1. Next state is HOLD (0 bytes) or OP_LO.
  - OP_LO: `mem_read`=1. Capture into `operand[7:0]`, clear `operand[15:8]`, then PC+1. Next state is HOLD (1 byte) or OP_HI.
  - OP_HI: `mem_read`=1. Capture into `operand[15:8]`, then PC+1. Next state is HOLD.
  - HOLD: `instr_valid`=1. Outputs stay stable until `instr_ready`=1. After that handshake the next state is OPC if `fetch_req` is 1, else IDLE.
- OPC clears `operand` to 0.
- PC arithmetic is modulo 2^ADDR_W: 16'hFFFF+1 = 16'h0000. A multi-byte instruction may straddle the wrap.
- `jump` has priority in every state:
  - PC is loaded with `jump_addr`.
  - Any partial fetch is discarded and `instr_valid` drops on the next edge.
  - Next state is OPC if `fetch_req` is 1, else IDLE.
- `jump` and a handshake in the same cycle: the transfer counts as completed, then the jump is applied.
- `fetch_req` dropping mid-fetch does not abort the fetch. The current instruction completes to HOLD.
- The block never asserts a memory write.

## Timing
- Reset values:
  - State: IDLE.
  - PC and `mem_addr`: RESET_PC.
  - `mem_read`=0, `instr_valid`=0.
  - `opcode`=0, `operand`=0, `instr_pc`=RESET_PC.
- Assertion of `rst` mid-fetch returns the block to these values immediately, without waiting for a clock edge.
- Latency, counted from the edge that samples `fetch_req` in IDLE to the first cycle of `instr_valid`: 2 cycles for 0 operand bytes, 3 for 1, 4 for 2.
- Back-to-back throughput: one instruction per (1 + length) + 1 cycles. HOLD always costs at least one cycle.
- `mem_read` and `mem_addr` are registered-state outputs and glitch-free within a cycle. `mem_data` is sampled at the end of the same cycle.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (IDLE, OPC, OP_LO, OP_HI, HOLD);
  - the opcode-length field position [7:6] and the length encodings;
  - the function `operand_len(opcode)`, which returns 0, 1 or 2.
- Single module with no sub-module. The PC register and the assembly registers are inline.

## Test plan
- Memory holds 0x00=8'h01, `fetch_req`=1, `instr_ready`=1. Expect `opcode`=8'h01, `operand`=0, `instr_pc`=0, with `instr_valid` 2 cycles after the request. The next fetch then reads address 1.
- Memory holds 0x10=8'h4F, 0x11=8'h3F. After a jump to 0x10, expect `opcode`=8'h4F, `operand`=16'h003F, and PC=0x12 afterwards.
- Memory holds 0x20=8'h80, 0x21=8'h34, 0x22=8'h12. Expect `operand`=16'h1234, `instr_valid` 4 cycles after the request, and PC=0x23.
- Hold `instr_ready`=0 for 5 cycles in HOLD. Expect outputs stable and `mem_read`=0 throughout. Raise `instr_ready`: exactly one transfer occurs and a new OPC read follows.
- Pulse `jump` to 0x0040 while in OP_LO. Expect the partial instruction discarded, no `instr_valid`, and the next opcode read at 0x0040.
- Set PC to 16'hFFFF with a 2-byte opcode there. Expect the operand read from 0x0000 and 0x0001, and PC=0x0002. Assert `rst` mid-fetch: all outputs are at their reset values before the next edge.
